// File: rtl/niox_bd_pkg.sv
// Shared command codes, state encoding and sector geometry for the NIOX block-device responder.
package niox_bd_pkg;

  localparam logic [1:0] BD_CMD_RESET = 2'd0;
  localparam logic [1:0] BD_CMD_READ  = 2'd1;
  localparam logic [1:0] BD_CMD_WRITE = 2'd2;

  localparam int unsigned BD_SECTOR_WORDS = 256;
  localparam logic [7:0]  BD_LAST_WORD    = 8'(BD_SECTOR_WORDS - 1);

  // Encodings are visible to software through bd_state[11:8].
  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StRdFetch = 4'd1,
    StRdWait  = 4'd2,
    StWrWait  = 4'd3,
    StDone    = 4'd4
  } bd_state_e;

endpackage

// File: rtl/niox_bd_ram.sv
// Single-port synchronous disk-image RAM, 16-bit words, one-cycle read latency.
module niox_bd_ram #(
  parameter int unsigned AddrWidth = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [AddrWidth-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [2**AddrWidth];

  // Array has no reset so the disk image survives a controller reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/niox_bd_disk.sv
// Block-device responder behind the spy bridge: sector read/write commands served from
// an internal RAM image, one word per bd_rd/bd_wr pulse.
module niox_bd_disk
  import niox_bd_pkg::*;
#(
  parameter int unsigned SECTORS_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  bd_cmd,
  input  logic        bd_start,
  input  logic [23:0] bd_addr,
  input  logic [15:0] bd_data_in,
  input  logic        bd_rd,
  input  logic        bd_wr,
  output logic [15:0] bd_data_out,
  output logic        bd_bsy,
  output logic        bd_rdy,
  output logic        bd_err,
  output logic        bd_iordy,
  output logic [15:0] bd_state
);

  localparam int unsigned AddrWidth = SECTORS_LOG2 + 8;

  bd_state_e               state_q, state_d;
  logic [7:0]              count_q, count_d;
  logic [SECTORS_LOG2-1:0] lba_q, lba_d;
  logic                    err_q, err_d;
  logic                    ram_we, ram_re;
  logic                    addr_oob;

  assign addr_oob = (bd_addr >> SECTORS_LOG2) != 24'd0;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lba_d   = lba_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bd_start) begin
          lba_d   = bd_addr[SECTORS_LOG2-1:0];
          count_d = '0;
          err_d   = 1'b0;
          if (bd_cmd == BD_CMD_RESET) begin
            state_d = StDone;
          end else if ((bd_cmd != BD_CMD_READ && bd_cmd != BD_CMD_WRITE) || addr_oob) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (bd_cmd == BD_CMD_READ) begin
            state_d = StRdFetch;
          end else begin
            state_d = StWrWait;
          end
        end
      end
      // Abort (bd_start low) takes priority over any same-cycle data strobe.
      StRdFetch: begin
        if (!bd_start) begin
          state_d = StIdle;
          count_d = '0;
        end else begin
          ram_re  = 1'b1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (!bd_start) begin
          state_d = StIdle;
          count_d = '0;
        end else if (bd_rd) begin
          if (count_q == BD_LAST_WORD) begin
            state_d = StDone;
            count_d = '0;
          end else begin
            state_d = StRdFetch;
            count_d = count_q + 8'd1;
          end
        end
      end
      StWrWait: begin
        if (!bd_start) begin
          state_d = StIdle;
          count_d = '0;
        end else if (bd_wr) begin
          ram_we = 1'b1;
          if (count_q == BD_LAST_WORD) begin
            state_d = StDone;
            count_d = '0;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
      end
      StDone: begin
        if (!bd_start) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      lba_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lba_q   <= lba_d;
      err_q   <= err_d;
    end
  end

  niox_bd_ram #(
    .AddrWidth(AddrWidth)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr ({lba_q, count_q}),
    .wdata(bd_data_in),
    .rdata(bd_data_out)
  );

  assign bd_bsy   = (state_q == StRdFetch) || (state_q == StRdWait) || (state_q == StWrWait);
  assign bd_rdy   = (state_q == StRdWait) || (state_q == StWrWait);
  assign bd_err   = err_q;
  assign bd_iordy = (state_q != StRdFetch);
  assign bd_state = {4'b0000, 4'(state_q), count_q};

endmodule

// File: tb/tb_niox_bd_disk.sv
// Scenario bench for niox_bd_disk; read data is checked through a queue-based scoreboard.
module tb_niox_bd_disk;

  localparam int unsigned Words = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  bd_cmd = 2'd0;
  logic        bd_start = 1'b0;
  logic [23:0] bd_addr = 24'd0;
  logic [15:0] bd_data_in = 16'd0;
  logic        bd_rd = 1'b0;
  logic        bd_wr = 1'b0;
  logic [15:0] bd_data_out;
  logic        bd_bsy, bd_rdy, bd_err, bd_iordy;
  logic [15:0] bd_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [Words];
  bit          known [Words];
  logic [15:0] sb_q  [$];
  bit          kn_q  [$];

  niox_bd_disk #(
    .SECTORS_LOG2(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bd_cmd     (bd_cmd),
    .bd_start   (bd_start),
    .bd_addr    (bd_addr),
    .bd_data_in (bd_data_in),
    .bd_rd      (bd_rd),
    .bd_wr      (bd_wr),
    .bd_data_out(bd_data_out),
    .bd_bsy     (bd_bsy),
    .bd_rdy     (bd_rdy),
    .bd_err     (bd_err),
    .bd_iordy   (bd_iordy),
    .bd_state   (bd_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [1:0] cmd, input logic [23:0] addr);
    bd_cmd   = cmd;
    bd_addr  = addr;
    bd_start = 1'b1;
    step();
  endtask

  task automatic wr_word(input logic [15:0] d, input int a);
    bd_wr      = 1'b1;
    bd_data_in = d;
    step();
    bd_wr      = 1'b0;
    model[a]   = d;
    known[a]   = 1'b1;
  endtask

  // Full-sector read; expected words are queued at command issue and popped as words appear.
  task automatic read_sector_sb(input int lba, input string tag);
    logic [15:0] exp;
    bit          k;
    int          waited;
    sb_q.delete();
    kn_q.delete();
    for (int i = 0; i < 256; i++) begin
      sb_q.push_back(model[lba * 256 + i]);
      kn_q.push_back(known[lba * 256 + i]);
    end
    start_cmd(2'd1, 24'(lba));
    checks++;
    if (bd_state !== 16'h0100 || bd_iordy !== 1'b0 || bd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_fetch0: state=%h iordy=%b rdy=%b, want 0100/0/0", tag, bd_state,
               bd_iordy, bd_rdy);
    end
    for (int i = 0; i < 256; i++) begin
      waited = 0;
      while (bd_state[11:8] !== 4'd2 && waited < 4) begin
        step();
        waited++;
      end
      checks++;
      if (bd_state[11:8] !== 4'd2 || bd_rdy !== 1'b1 || bd_iordy !== 1'b1) begin
        errors++;
        $display("FAIL %s_wait word %0d: state=%h rdy=%b iordy=%b, want RD_WAIT rdy=1 iordy=1",
                 tag, i, bd_state, bd_rdy, bd_iordy);
        bd_start = 1'b0;
        step();
        step();
        return;
      end
      exp = sb_q.pop_front();
      k   = kn_q.pop_front();
      if (k) begin
        checks++;
        if (bd_data_out !== exp) begin
          errors++;
          $display("FAIL %s_data word %0d: got %h want %h", tag, i, bd_data_out, exp);
        end
      end
      checks++;
      if (bd_state[7:0] !== 8'(i)) begin
        errors++;
        $display("FAIL %s_count: got %h want %h", tag, bd_state[7:0], 8'(i));
      end
      bd_rd = 1'b1;
      step();
      bd_rd = 1'b0;
      if (i < 255) begin
        checks++;
        if (bd_state[11:8] !== 4'd1 || bd_iordy !== 1'b0 || bd_rdy !== 1'b0) begin
          errors++;
          $display("FAIL %s_refetch word %0d: state=%h iordy=%b rdy=%b", tag, i, bd_state,
                   bd_iordy, bd_rdy);
        end
      end
    end
    checks++;
    if (bd_state !== 16'h0400 || bd_bsy !== 1'b0 || bd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: state=%h bsy=%b rdy=%b, want 0400/0/0", tag, bd_state, bd_bsy,
               bd_rdy);
    end
    bd_start = 1'b0;
    step();
    checks++;
    if (bd_state !== 16'h0000) begin
      errors++;
      $display("FAIL %s_idle: state=%h want 0000", tag, bd_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bd_bsy, bd_rdy, bd_err, bd_iordy} !== 4'b0001 || bd_state !== 16'h0000 ||
        bd_data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset: bsy/rdy/err/iordy=%b state=%h dout=%h, want 0001/0000/0000",
               {bd_bsy, bd_rdy, bd_err, bd_iordy}, bd_state, bd_data_out);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    start_cmd(2'd2, 24'd3);
    checks++;
    if (bd_state !== 16'h0300 || bd_rdy !== 1'b1 || bd_bsy !== 1'b1) begin
      errors++;
      $display("FAIL wr_start: state=%h rdy=%b bsy=%b, want 0300/1/1", bd_state, bd_rdy, bd_bsy);
    end
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        checks++;
        if (bd_bsy !== 1'b1 || bd_state !== 16'h03FF) begin
          errors++;
          $display("FAIL wr_last_pre: bsy=%b state=%h, want 1/03ff", bd_bsy, bd_state);
        end
      end
      wr_word(16'h3000 + 16'(i), 3 * 256 + i);
    end
    checks++;
    if (bd_bsy !== 1'b0 || bd_state !== 16'h0400 || bd_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: bsy=%b state=%h err=%b, want 0/0400/0", bd_bsy, bd_state, bd_err);
    end
    bd_start = 1'b0;
    step();
    read_sector_sb(3, "rd_s3");
  endtask

  task automatic test_out_of_range();
    start_cmd(2'd1, 24'd16);
    checks++;
    if (bd_err !== 1'b1 || bd_bsy !== 1'b0 || bd_state !== 16'h0400) begin
      errors++;
      $display("FAIL oob: err=%b bsy=%b state=%h, want 1/0/0400", bd_err, bd_bsy, bd_state);
    end
    bd_start = 1'b0;
    step();
    start_cmd(2'd1, 24'd0);
    checks++;
    if (bd_err !== 1'b0 || bd_state !== 16'h0100) begin
      errors++;
      $display("FAIL oob_clear: err=%b state=%h, want 0/0100", bd_err, bd_state);
    end
    bd_start = 1'b0;
    step();
  endtask

  task automatic test_read_timing();
    start_cmd(2'd1, 24'd1);
    checks++;
    if (bd_state !== 16'h0100 || bd_iordy !== 1'b0 || bd_rdy !== 1'b0 || bd_bsy !== 1'b1) begin
      errors++;
      $display("FAIL rt_e1: state=%h iordy=%b rdy=%b bsy=%b", bd_state, bd_iordy, bd_rdy, bd_bsy);
    end
    step();
    checks++;
    if (bd_state !== 16'h0200 || bd_rdy !== 1'b1 || bd_iordy !== 1'b1) begin
      errors++;
      $display("FAIL rt_e2: state=%h rdy=%b iordy=%b, want 0200/1/1", bd_state, bd_rdy, bd_iordy);
    end
    for (int i = 1; i <= 4; i++) begin
      bd_rd = 1'b1;
      step();
      bd_rd = 1'b0;
      checks++;
      if (bd_state !== 16'h0100 + 16'(i) || bd_iordy !== 1'b0 || bd_rdy !== 1'b0) begin
        errors++;
        $display("FAIL rt_fetch %0d: state=%h iordy=%b rdy=%b", i, bd_state, bd_iordy, bd_rdy);
      end
      step();
      checks++;
      if (bd_state !== 16'h0200 + 16'(i) || bd_iordy !== 1'b1 || bd_rdy !== 1'b1) begin
        errors++;
        $display("FAIL rt_wait %0d: state=%h iordy=%b rdy=%b", i, bd_state, bd_iordy, bd_rdy);
      end
    end
    // Abort with a simultaneous bd_rd: abort wins.
    bd_start = 1'b0;
    bd_rd    = 1'b1;
    step();
    bd_rd = 1'b0;
    checks++;
    if (bd_state !== 16'h0000 || bd_err !== 1'b0) begin
      errors++;
      $display("FAIL rt_abort: state=%h err=%b, want 0000/0", bd_state, bd_err);
    end
  endtask

  task automatic test_abort_write();
    start_cmd(2'd2, 24'd3);
    for (int i = 0; i < 10; i++) begin
      wr_word(16'hA000 + 16'(i), 3 * 256 + i);
    end
    // The strobe in the abort cycle must not land in RAM.
    bd_start   = 1'b0;
    bd_wr      = 1'b1;
    bd_data_in = 16'hDEAD;
    step();
    bd_wr = 1'b0;
    checks++;
    if (bd_state !== 16'h0000 || bd_err !== 1'b0 || bd_bsy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wr: state=%h err=%b bsy=%b, want 0000/0/0", bd_state, bd_err, bd_bsy);
    end
    read_sector_sb(3, "rd_abort");
  endtask

  task automatic test_reset_midread();
    start_cmd(2'd1, 24'd3);
    step();
    for (int i = 0; i < 'h40; i++) begin
      bd_rd = 1'b1;
      step();
      bd_rd = 1'b0;
      step();
    end
    checks++;
    if (bd_state !== 16'h0240) begin
      errors++;
      $display("FAIL mid_pos: state=%h want 0240", bd_state);
    end
    reset    = 1'b1;
    bd_start = 1'b0;
    step();
    checks++;
    if ({bd_bsy, bd_rdy, bd_err, bd_iordy} !== 4'b0001 || bd_state !== 16'h0000 ||
        bd_data_out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: bsy/rdy/err/iordy=%b state=%h dout=%h, want 0001/0000/0000",
               {bd_bsy, bd_rdy, bd_err, bd_iordy}, bd_state, bd_data_out);
    end
    reset = 1'b0;
    step();
    read_sector_sb(3, "rd_after_reset");
  endtask

  task automatic test_illegal();
    start_cmd(2'd3, 24'd3);
    checks++;
    if (bd_err !== 1'b1 || bd_state !== 16'h0400 || bd_bsy !== 1'b0) begin
      errors++;
      $display("FAIL illegal: err=%b state=%h bsy=%b, want 1/0400/0", bd_err, bd_state, bd_bsy);
    end
    bd_rd = 1'b1;
    step();
    bd_rd = 1'b0;
    checks++;
    if (bd_state !== 16'h0400) begin
      errors++;
      $display("FAIL done_rd: state=%h want 0400", bd_state);
    end
    bd_wr      = 1'b1;
    bd_data_in = 16'hBEEF;
    step();
    bd_wr = 1'b0;
    checks++;
    if (bd_state !== 16'h0400 || bd_err !== 1'b1) begin
      errors++;
      $display("FAIL done_wr: state=%h err=%b, want 0400/1", bd_state, bd_err);
    end
    bd_start = 1'b0;
    step();
    checks++;
    if (bd_state !== 16'h0000 || bd_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_idle: state=%h err=%b, want 0000/1", bd_state, bd_err);
    end
    read_sector_sb(3, "rd_after_illegal");
  endtask

  initial begin
    for (int i = 0; i < Words; i++) begin
      known[i] = 1'b0;
      model[i] = 16'h0000;
    end
    test_reset();
    test_write_read();
    test_out_of_range();
    test_read_timing();
    test_abort_write();
    test_reset_midread();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/niox_bd_disk.md
# niox_bd_disk

Block-device responder that terminates the `bd_*` command/data interface driven by the NIOX spy register bridge. It accepts read/write sector commands and serves them from an internal RAM-backed disk image, one 16-bit word per `bd_rd`/`bd_wr` pulse. Status is returned on `bd_bsy`/`bd_rdy`/`bd_err`/`bd_iordy`/`bd_state`. It is the simulation and FPGA stand-in for a real disk controller behind the spy interface.

## Interface

Parameters:
- `SECTORS_LOG2`, default 4: disk holds 2^SECTORS_LOG2 sectors of 256 words each (default 4096 words).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `bd_cmd` in 2: command; 0 = reset, 1 = read, 2 = write, 3 = illegal.
- `bd_start` in 1: level; command is accepted while high in IDLE. Must drop to end a command.
- `bd_addr` in 24: sector number (LBA).
- `bd_data_in` in 16: write data, sampled on a `bd_wr` cycle.
- `bd_rd` in 1: one-cycle pulse; consume the current read word.
- `bd_wr` in 1: one-cycle pulse; store `bd_data_in`.
- `bd_data_out` out 16: current read word.
- `bd_bsy` out 1: command in progress.
- `bd_rdy` out 1: word available (read) or word slot open (write).
- `bd_err` out 1: last command failed.
- `bd_iordy` out 1: low only while a RAM fetch is in flight.
- `bd_state` out 16: bits [15:12] = 0, [11:8] = state code, [7:0] = word count.

## Operation

States and codes: IDLE=0, RD_FETCH=1, RD_WAIT=2, WR_WAIT=3, DONE=4.
- Reset values: state IDLE, word count 0, `bd_bsy`=0, `bd_rdy`=0, `bd_err`=0, `bd_iordy`=1, `bd_data_out`=0, `bd_state`=0. RAM contents are not cleared.
- IDLE with `bd_start`=1:
  - Latch `bd_cmd` and `bd_addr`, clear count, clear `bd_err`.
  - cmd 0: go to DONE.
  - cmd 3, or cmd 1/2 with `bd_addr` ≥ 2^SECTORS_LOG2: set `bd_err`, go to DONE.
  - cmd 1: go to RD_FETCH.
  - cmd 2: go to WR_WAIT.
- RD_FETCH: issue a RAM read at {lba, count}; `bd_iordy`=0; next state RD_WAIT.
- RD_WAIT: `bd_data_out` holds the word and `bd_rdy`=1. On `bd_rd`:
  - count = 255: go to DONE.
  - otherwise: count+1 and go to RD_FETCH.
- WR_WAIT: `bd_rdy`=1. On `bd_wr`, write `bd_data_in` to {lba, count} on that edge.
  - count = 255: go to DONE.
  - otherwise: count+1 and stay in WR_WAIT.
- DONE: `bd_bsy`=0, `bd_rdy`=0, `bd_err` holds. Go to IDLE when `bd_start`=0.
- `bd_bsy`=1 in RD_FETCH, RD_WAIT and WR_WAIT.
- Abort: `bd_start`=0 in RD_FETCH, RD_WAIT or WR_WAIT sends the block to IDLE and clears count. Words already written remain. `bd_err` is not set.
- Ignored inputs:
  - `bd_rd` outside RD_WAIT.
  - `bd_wr` outside WR_WAIT.
  - In RD_WAIT, `bd_wr` is ignored; in WR_WAIT, `bd_rd` is ignored.
  - `bd_cmd` and `bd_addr` changes after acceptance.
- Priority: abort (`bd_start` low) beats a same-cycle `bd_rd`/`bd_wr`. The word is neither consumed nor written.
- Address arithmetic: RAM address = {lba[SECTORS_LOG2-1:0], count[7:0]}. Count never wraps past 255 within a command.

## Timing

- Read, start sampled high at edge E:
  - RD_FETCH during cycle E+1.
  - `bd_rdy`=1 and first word valid on `bd_data_out` from edge E+2.
  - Each `bd_rd` at edge R gives `bd_rdy`=0 for cycle R+1 and the next word with `bd_rdy`=1 from R+2.
- Write: `bd_rdy`=1 from edge E+1. The block accepts one word per cycle if `bd_wr` pulses back-to-back.
- Last word (`bd_rd` or `bd_wr` at count 255) at edge L: DONE from L+1, so `bd_bsy` falls at L+1.
- `bd_state` is registered alongside state and count; it has no combinational path from inputs.
- `bd_data_out` changes only on the RD_FETCH→RD_WAIT edge.

## Structure

- Package `niox_bd_pkg`:
  - Command codes `BD_CMD_RESET`, `BD_CMD_READ`, `BD_CMD_WRITE`.
  - State codes (4-bit).
  - `BD_SECTOR_WORDS` = 256.
- Sub-module `niox_bd_ram`: single-port synchronous RAM, 16 bits × 2^(SECTORS_LOG2+8).
  - One-cycle read latency.
  - Write-first is not required, because a read and a write never share a cycle.
- Top `niox_bd_disk`: FSM, counter, latched cmd/lba, status outputs.

## Test plan

- Write sector 3 with pattern 0x3000+i (256 `bd_wr` pulses), drop `bd_start`, then read sector 3 → 256 words 0x3000..0x30FF. `bd_bsy` falls one cycle after the last pulse. `bd_state` reads 0x0400 in DONE after the read (count reset to 0 on the final word).
- Read with `bd_addr`=16 (SECTORS_LOG2=4) → `bd_err`=1 and `bd_bsy`=0 within 1 cycle. A following read of sector 0 clears `bd_err`.
- Read sector 1: check `bd_rdy` 2 cycles after start, `bd_iordy`=0 only in RD_FETCH, and `bd_state[11:8]` alternating 1/2 with count incrementing.
- Abort a write after 10 words by dropping `bd_start` → IDLE next cycle, no error. A readback shows the first 10 new words and the remaining 246 old words.
- Assert `reset` mid-read (count=0x40) → all outputs at reset values next cycle. RAM is intact on a subsequent read.
- `bd_cmd`=3 → `bd_err`=1, DONE. Pulse `bd_rd` and `bd_wr` while in DONE → no state or RAM change.
